// File: rtl/rf_exec_pkg.sv
// Shared opcode, FSM-state and default-size definitions for the register-file
// execution stage.
package rf_exec_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AW    = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    WB   = 2'b10
  } state_e;

endpackage

// File: rtl/rf_exec_mul8.sv
// Iterative shift-add multiplier: load captures operands, each step consumes
// one multiplier bit; done_o flags the step that yields the final product.
module rf_exec_mul8 #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   prod_nxt_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] partial;

  assign partial    = mplier_q[0] ? mcand_q : '0;
  assign prod_nxt_o = acc_q + partial;
  assign done_o     = step_i && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d    = prod_nxt_o;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_exec_unit.sv
// Execution stage behind register_file: one ALU op per accepted command,
// result written back through WEN/RW/busW with a start/busy/done handshake.
module rf_exec_unit
  import rf_exec_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd,
  input  logic [WIDTH-1:0] busX,
  input  logic [WIDTH-1:0] busY,
  output logic             busy,
  output logic             done,
  output logic             WEN,
  output logic [AW-1:0]    RW,
  output logic [WIDTH-1:0] busW,
  output logic             carry
);

  state_e             state_q, state_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [AW-1:0]      rw_q, rw_d;
  logic [WIDTH-1:0]   busw_q, busw_d;
  logic               carry_q, carry_d;
  logic               mul_load, mul_step, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     alu_res;

  // Single-cycle ops; bit WIDTH is the carry/borrow flag.
  function automatic logic [WIDTH:0] alu_simple(input logic [2:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH:0] r;
    r = '0;
    case (f)
      OP_ADD:  r = {1'b0, x} + {1'b0, y};
      OP_SUB:  r = {1'b0, x} - {1'b0, y};
      OP_AND:  r = {1'b0, x & y};
      OP_OR:   r = {1'b0, x | y};
      OP_XOR:  r = {1'b0, x ^ y};
      OP_SHL:  r = {1'b0, x << y[2:0]};
      OP_SHR:  r = {1'b0, x >> y[2:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_res = alu_simple(op, busX, busY);

  rf_exec_mul8 #(.WIDTH(WIDTH)) u_mul (
    .Clk        (Clk),
    .Rst        (Rst),
    .load_i     (mul_load),
    .step_i     (mul_step),
    .a_i        (busX),
    .b_i        (busY),
    .done_o     (mul_done),
    .prod_nxt_o (mul_prod)
  );

  // Result registers only change on entry to WB so they hold between writes.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    busw_d   = busw_q;
    carry_d  = carry_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rd_d = rd;
          if (op == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = MUL;
          end else begin
            {carry_d, busw_d} = alu_res;
            rw_d    = rd;
            state_d = WB;
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (mul_done) begin
          busw_d  = mul_prod[WIDTH-1:0];
          carry_d = |mul_prod[2*WIDTH-1:WIDTH];
          rw_d    = rd_q;
          state_d = WB;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      rd_q    <= '0;
      rw_q    <= '0;
      busw_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      busw_q  <= busw_d;
      carry_q <= carry_d;
    end
  end

  // Writes to r0 are suppressed but still complete the handshake.
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == WB);
  assign WEN   = done && (rw_q != '0);
  assign RW    = rw_q;
  assign busW  = busw_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_rf_exec_unit.sv
// Directed bench for rf_exec_unit: expected write-backs are queued at issue
// time and checked when the unit reaches its write-back cycle.
module tb_rf_exec_unit;
  import rf_exec_pkg::*;

  localparam int W = 8;
  localparam int A = 3;

  logic         Clk = 1'b0;
  logic         Rst, start;
  logic [2:0]   op;
  logic [A-1:0] rd;
  logic [W-1:0] busX, busY;
  logic         busy, done, WEN, carry;
  logic [A-1:0] RW;
  logic [W-1:0] busW;

  typedef struct {
    logic [A-1:0] rd;
    logic [W-1:0] res;
    logic         cy;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   writes = 0;
  int   w0;

  rf_exec_unit #(.WIDTH(W), .AW(A)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (start),
    .op    (op),
    .rd    (rd),
    .busX  (busX),
    .busY  (busY),
    .busy  (busy),
    .done  (done),
    .WEN   (WEN),
    .RW    (RW),
    .busW  (busW),
    .carry (carry)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (WEN === 1'b1) writes++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [2:0] f, input int x, input int y);
    int r;
    bit cy;
    cy = 1'b0;
    case (f)
      3'd0: begin r = x + y; cy = (r > 255); end
      3'd1: begin r = x - y + 256; cy = (x < y); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x << (y % 8);
      3'd6: r = x >> (y % 8);
      default: begin r = x * y; cy = (r > 255); end
    endcase
    return {cy, W'(r % 256)};
  endfunction

  task automatic issue(input logic [2:0] f, input logic [A-1:0] d,
                       input logic [W-1:0] x, input logic [W-1:0] y, input bit queue_it);
    logic [W:0] m;
    exp_t e;
    @(negedge Clk);
    start = 1'b1; op = f; rd = d; busX = x; busY = y;
    if (queue_it) begin
      m = model(f, x, y);
      e.rd = d; e.res = m[W-1:0]; e.cy = m[W];
      sb.push_back(e);
    end
    @(posedge Clk); #1;
    start = 1'b0; busX = W'($urandom); busY = W'($urandom); op = 3'($urandom);
  endtask

  task automatic wait_wb(input string tag, input int exp_edges);
    int n;
    exp_t e;
    n = 0;
    chk({tag, "_busy"}, busy, 1);
    while (done !== 1'b1 && n < 40) begin
      @(posedge Clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, exp_edges);
    chk({tag, "_sb"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_done"}, done, 1);
      chk({tag, "_wen"}, WEN, e.rd != 0);
      chk({tag, "_rw"}, RW, e.rd);
      chk({tag, "_busw"}, busW, e.res);
      chk({tag, "_carry"}, carry, e.cy);
      @(posedge Clk); #1;
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_done_off"}, done, 0);
      chk({tag, "_wen_off"}, WEN, 0);
      chk({tag, "_busw_hold"}, busW, e.res);
      chk({tag, "_rw_hold"}, RW, e.rd);
    end
  endtask

  initial begin
    Rst = 1'b1; start = 1'b0; op = '0; rd = '0; busX = '0; busY = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wen", WEN, 0);
    chk("rst_rw", RW, 0);
    chk("rst_busw", busW, 0);
    chk("rst_carry", carry, 0);
    @(negedge Clk);
    Rst = 1'b0;

    issue(OP_ADD, 3'd3, 8'd200, 8'd100, 1'b1);
    wait_wb("add", 0);
    issue(OP_SUB, 3'd2, 8'd5, 8'd7, 1'b1);
    wait_wb("sub", 0);
    issue(OP_SUB, 3'd2, 8'd9, 8'd9, 1'b1);
    wait_wb("sub_eq", 0);
    issue(OP_XOR, 3'd4, 8'hF0, 8'h3C, 1'b1);
    wait_wb("xor", 0);
    issue(OP_AND, 3'd6, 8'hF0, 8'h3C, 1'b1);
    wait_wb("and", 0);
    issue(OP_OR, 3'd7, 8'hF0, 8'h3C, 1'b1);
    wait_wb("or", 0);
    issue(OP_SHL, 3'd1, 8'h81, 8'd1, 1'b1);
    wait_wb("shl1", 0);
    issue(OP_SHR, 3'd6, 8'h81, 8'd7, 1'b1);
    wait_wb("shr7", 0);
    issue(OP_SHL, 3'd5, 8'hA5, 8'hF8, 1'b1);
    wait_wb("shl0", 0);
    issue(OP_SHL, 3'd5, 8'hFF, 8'd7, 1'b1);
    wait_wb("shl7", 0);

    issue(OP_MUL, 3'd5, 8'd13, 8'd11, 1'b1);
    wait_wb("mul13x11", W);
    issue(OP_MUL, 3'd7, 8'd16, 8'd32, 1'b1);
    wait_wb("mul16x32", W);
    issue(OP_MUL, 3'd1, 8'd255, 8'd255, 1'b1);
    wait_wb("mul255", W);

    w0 = writes;
    issue(OP_ADD, 3'd0, 8'd1, 8'd1, 1'b1);
    wait_wb("rd0", 0);
    chk("rd0_nowrite", writes, w0);

    w0 = writes;
    issue(OP_MUL, 3'd2, 8'd9, 8'd7, 1'b1);
    repeat (3) @(negedge Clk);
    start = 1'b1; op = OP_ADD; rd = 3'd6; busX = 8'd1; busY = 8'd1;
    @(posedge Clk); #1;
    start = 1'b0;
    wait_wb("mul_ign", W - 3);
    repeat (2) begin
      @(posedge Clk); #1;
      chk("mul_ign_quiet", busy, 0);
    end
    chk("mul_ign_writes", writes, w0 + 1);

    w0 = writes;
    @(negedge Clk);
    start = 1'b1; op = OP_ADD; rd = 3'd1; busX = 8'd10; busY = 8'd20;
    sb.push_back('{3'd1, 8'd30, 1'b0});
    @(posedge Clk); #1;
    op = OP_SUB; rd = 3'd2; busX = 8'd3; busY = 8'd4;
    sb.push_back('{3'd2, 8'd255, 1'b1});
    wait_wb("b2b_1", 0);
    @(posedge Clk); #1;
    start = 1'b0;
    wait_wb("b2b_2", 0);
    chk("b2b_writes", writes, w0 + 2);

    w0 = writes;
    issue(OP_MUL, 3'd5, 8'd13, 8'd11, 1'b0);
    repeat (4) @(posedge Clk);
    #3;
    Rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wen", WEN, 0);
    chk("abort_busw", busW, 0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    chk("abort_nowrite", writes, w0);
    issue(OP_ADD, 3'd3, 8'd1, 8'd2, 1'b1);
    wait_wb("post_rst", 0);
    chk("post_rst_writes", writes, w0 + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
